freepdk45_sram_arb_2p_64x80: RTL

- Two-requester round-robin arbiter and sequencer for the single RW port of the 64x80 OpenRAM macro (4 write-mask lanes of 20 bits).
- Accepts up to one request per cycle and drives registered SRAM port signals.
- Captures read data at the correct edge and returns it to the owning requester.
- After reset, runs a zero-fill sweep of the whole array before granting any requests.

---
 rtl/freepdk45_sram_arb_pkg.sv | 21 ++
 rtl/freepdk45_sram_arb_rr2.sv | 33 +++
 rtl/freepdk45_sram_arb_2p_64x80.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/freepdk45_sram_arb_pkg.sv
// Shared constants and types for the 64x80 single-port SRAM arbiter.
package freepdk45_sram_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DATA_WIDTH = 80;
    localparam int ADDR_WIDTH = 6;
    localparam int NUM_WMASKS = 4;
    localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;
    localparam int STAT_WIDTH = 16;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/freepdk45_sram_arb_rr2.sv
// Two-way round-robin grant; the pointer names the winner of the next contested cycle.
module freepdk45_sram_arb_rr2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        ptr_d = ptr_q;
        if (en_i) begin
            if (valid_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end else begin
                gnt_o = valid_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/freepdk45_sram_arb_2p_64x80.sv
// Round-robin sequencer for the single RW port of the 64x80 SRAM, zero-fills the array after reset.
// Optional FREEPDK45_SRAM_ARB_STATS_EN adds grant/conflict counters.
//   state | meaning
//   INIT  | zero-fill sweep of addresses 0..63, no grants
//   RUN   | arbitrate requests, issue SRAM accesses, return read data
module freepdk45_sram_arb_2p_64x80
    import freepdk45_sram_arb_pkg::*;
(
    input  logic                            clk0,
    input  logic                            rst0_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*NUM_WMASKS-1:0]   req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            init_done,
    output logic                            csb0,
    output logic                            web0,
    output logic [NUM_WMASKS-1:0]           wmask0,
    output logic [ADDR_WIDTH-1:0]           addr0,
    output logic [DATA_WIDTH-1:0]           din0,
    input  logic [DATA_WIDTH-1:0]           dout0
`ifdef FREEPDK45_SRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0]   grant_cnt,
    output logic [STAT_WIDTH-1:0]           conflict_cnt
`endif
);

    arb_state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]       cnt_q, cnt_d;
    logic                      init_done_q, init_done_d;
    logic                      csb_q, csb_d;
    logic                      web_q, web_d;
    logic [NUM_WMASKS-1:0]     wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     din_q, din_d;
    rd_tag_t                   tag1_q, tag1_d, tag2_q, tag2_d;
    logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [NUM_REQ-1:0]        gnt;
    logic                      gid;

    freepdk45_sram_arb_rr2 u_rr2 (
        .clk_i   (clk0),
        .rst_ni  (rst0_n),
        .en_i    (state_q == RUN),
        .valid_i (req_valid),
        .gnt_o   (gnt)
    );

    assign gid       = gnt[1];
    assign req_ready = gnt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        csb_d       = 1'b1;
        web_d       = web_q;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        din_d       = din_q;
        tag1_d      = '0;
        tag2_d      = tag1_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;

        // dout0 is valid here: the SRAM sampled one edge ago and drove data on the negedge.
        if (tag2_q.valid) begin
            rsp_valid_d[tag2_q.id] = 1'b1;
            rsp_rdata_d            = dout0;
        end

        case (state_q)
            INIT: begin
                if (cnt_q[ADDR_WIDTH]) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    csb_d   = 1'b0;
                    web_d   = 1'b0;
                    wmask_d = '1;
                    din_d   = '0;
                    addr_d  = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d   = cnt_q + (ADDR_WIDTH+1)'(1);
                end
            end
            RUN: begin
                if (|gnt) begin
                    csb_d        = 1'b0;
                    web_d        = ~req_we[gid];
                    wmask_d      = req_wmask[int'(gid)*NUM_WMASKS +: NUM_WMASKS];
                    addr_d       = req_addr[int'(gid)*ADDR_WIDTH +: ADDR_WIDTH];
                    din_d        = req_wdata[int'(gid)*DATA_WIDTH +: DATA_WIDTH];
                    tag1_d.valid = ~req_we[gid];
                    tag1_d.id    = gid;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign csb0      = csb_q;
    assign web0      = web_q;
    assign wmask0    = wmask_q;
    assign addr0     = addr_q;
    assign din0      = din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

`ifdef FREEPDK45_SRAM_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_WIDTH-1:0] gcnt_q, gcnt_d;
    logic [STAT_WIDTH-1:0]              ccnt_q, ccnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        ccnt_d = ccnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (gcnt_q[i] != '1)) begin
                gcnt_d[i] = gcnt_q[i] + STAT_WIDTH'(1);
            end
        end
        if ((state_q == RUN) && (req_valid == 2'b11) && (ccnt_q != '1)) begin
            ccnt_d = ccnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk0) begin
        if (!rst0_n) begin
            gcnt_q <= '0;
            ccnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
            ccnt_q <= ccnt_d;
        end
    end

    assign grant_cnt    = gcnt_q;
    assign conflict_cnt = ccnt_q;
`endif

endmodule
